// File: rtl/vga_video_pkg.sv
// Shared definitions for the VGA video generator: pattern codes, box geometry,
// the colour-bar table and the raster-total helper.
package vga_video_pkg;

    localparam logic [2:0] PAT_SOLID    = 3'd0;
    localparam logic [2:0] PAT_BARS     = 3'd1;
    localparam logic [2:0] PAT_CHECKER  = 3'd2;
    localparam logic [2:0] PAT_GRADIENT = 3'd3;
    localparam logic [2:0] PAT_BOX      = 3'd4;

    localparam int unsigned BOX_SIZE = 32;
    localparam int unsigned BOX_DX   = 2;
    localparam int unsigned BOX_DY   = 1;

    function automatic int unsigned timing_total(input int unsigned active_len,
                                                 input int unsigned front_len,
                                                 input int unsigned sync_len,
                                                 input int unsigned back_len);
        return active_len + front_len + sync_len + back_len;
    endfunction

    // {r,g,b} of each bar, one bit per channel; indices past the last bar are black
    function automatic logic [2:0] bar_rgb(input logic [3:0] idx);
        logic [2:0] rgb;
        case (idx)
            4'd0:    rgb = 3'b111;
            4'd1:    rgb = 3'b110;
            4'd2:    rgb = 3'b011;
            4'd3:    rgb = 3'b010;
            4'd4:    rgb = 3'b101;
            4'd5:    rgb = 3'b100;
            4'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_timing_core.sv
// Raster counters with sync, blank and strobe decode. The decoded signals are
// combinational on the counter flops; vga_video_gen registers them.
module vga_timing_core
    import vga_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned X_BITS   = 12,
    parameter int unsigned Y_BITS   = 11
) (
    input  logic              clk_pixel,
    input  logic              reset,
    output logic [X_BITS-1:0] hc,
    output logic [Y_BITS-1:0] vc,
    output logic              active,
    output logic              hsync,
    output logic              vsync,
    output logic              line_start,
    output logic              frame_start,
    output logic              frame_end
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [X_BITS-1:0] H_LAST = X_BITS'(H_TOTAL - 1);
    localparam logic [X_BITS-1:0] H_ACT  = X_BITS'(H_ACTIVE);
    localparam logic [X_BITS-1:0] H_SS   = X_BITS'(H_ACTIVE + H_FP);
    localparam logic [X_BITS-1:0] H_SE   = X_BITS'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_BITS-1:0] V_LAST = Y_BITS'(V_TOTAL - 1);
    localparam logic [Y_BITS-1:0] V_ACT  = Y_BITS'(V_ACTIVE);
    localparam logic [Y_BITS-1:0] V_SS   = Y_BITS'(V_ACTIVE + V_FP);
    localparam logic [Y_BITS-1:0] V_SE   = Y_BITS'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
        $error("vga_timing_core: every H and V timing parameter must be >= 1");
    end

    logic [X_BITS-1:0] hc_q, hc_d;
    logic [Y_BITS-1:0] vc_q, vc_d;

    // Raster advance: hc wraps every line, vc steps on the hc wrap.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            if (vc_q == V_LAST) begin
                vc_d = '0;
            end else begin
                vc_d = vc_q + 1'b1;
            end
        end else begin
            hc_d = hc_q + 1'b1;
        end
    end

    // Counter flops; reset restarts the raster at (0,0).
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign active      = (hc_q < H_ACT) && (vc_q < V_ACT);
    assign hsync       = ((hc_q >= H_SS) && (hc_q < H_SE)) ? H_POL : ~H_POL;
    assign vsync       = ((vc_q >= V_SS) && (vc_q < V_SE)) ? V_POL : ~V_POL;
    assign line_start  = (hc_q == '0);
    assign frame_start = (hc_q == '0) && (vc_q == '0);
    assign frame_end   = (hc_q == H_LAST) && (vc_q == V_LAST);

endmodule

// File: rtl/vga_video_gen.sv
// Parametrised VGA timing and test-pattern generator. Every output is registered
// one cycle behind the raster counters; the pattern is latched at frame start.
module vga_video_gen
    import vga_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned C_BITS   = 8,
    parameter int unsigned X_BITS   = 12,
    parameter int unsigned Y_BITS   = 11
) (
    input  logic                clk_pixel,
    input  logic                reset,
    input  logic [2:0]          pattern_sel,
    input  logic [3*C_BITS-1:0] solid_rgb,
    output logic [C_BITS-1:0]   vga_r,
    output logic [C_BITS-1:0]   vga_g,
    output logic [C_BITS-1:0]   vga_b,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic                vga_blank,
    output logic [X_BITS-1:0]   pix_x,
    output logic [Y_BITS-1:0]   pix_y,
    output logic                line_start,
    output logic                frame_start,
    output logic [7:0]          frame_count
);

    localparam int unsigned       BAR_W    = H_ACTIVE / 8;
    localparam logic [X_BITS-1:0] BAR_LAST = X_BITS'((BAR_W > 0) ? BAR_W - 1 : 0);
    localparam logic [C_BITS-1:0] FULL     = {C_BITS{1'b1}};
    localparam logic [C_BITS-1:0] NONE     = {C_BITS{1'b0}};

    logic [X_BITS-1:0] hc_s;
    logic [Y_BITS-1:0] vc_s;
    logic              active_s, hsync_s, vsync_s;
    logic              line_start_s, frame_start_s, frame_end_s;

    vga_timing_core #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .H_POL    (H_POL),    .V_POL (V_POL),
        .X_BITS   (X_BITS),   .Y_BITS (Y_BITS)
    ) u_timing (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .hc          (hc_s),
        .vc          (vc_s),
        .active      (active_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .line_start  (line_start_s),
        .frame_start (frame_start_s),
        .frame_end   (frame_end_s)
    );

    logic [2:0]          pat_q, pat_d, pat_cur_s;
    logic [3:0]          bar_idx_q, bar_idx_d, bar_idx_cur_s;
    logic [X_BITS-1:0]   bar_cnt_q, bar_cnt_d, bar_cnt_cur_s;
    logic [X_BITS-1:0]   box_x_q, box_x_d;
    logic [Y_BITS-1:0]   box_y_q, box_y_d;
    logic [3*C_BITS-1:0] rgb_q, rgb_d, pattern_rgb_s;
    logic                blank_q, blank_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic                line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [7:0]          frame_count_q, frame_count_d;
    logic [X_BITS-1:0]   pix_x_q, pix_x_d;
    logic [Y_BITS-1:0]   pix_y_q, pix_y_d;
    logic [2:0]          bar_bits_s;
    logic [C_BITS-1:0]   grad_s;
    logic                in_box_s;

    // Pattern colour for the current counter position, plus next-state of the pattern state.
    always_comb begin
        // pattern_sel is honoured on the (0,0) cycle itself so the first pixel already uses it
        pat_cur_s     = frame_start_s ? pattern_sel : pat_q;
        bar_idx_cur_s = line_start_s ? 4'd0 : bar_idx_q;
        bar_cnt_cur_s = line_start_s ? '0 : bar_cnt_q;
        bar_bits_s    = bar_rgb(bar_idx_cur_s);
        grad_s        = C_BITS'(hc_s);
        in_box_s      = (hc_s >= box_x_q) && (hc_s < box_x_q + X_BITS'(BOX_SIZE)) &&
                        (vc_s >= box_y_q) && (vc_s < box_y_q + Y_BITS'(BOX_SIZE));

        case (pat_cur_s)
            PAT_SOLID:    pattern_rgb_s = solid_rgb;
            PAT_BARS:     pattern_rgb_s = {{C_BITS{bar_bits_s[2]}}, {C_BITS{bar_bits_s[1]}},
                                           {C_BITS{bar_bits_s[0]}}};
            PAT_CHECKER:  pattern_rgb_s = (hc_s[4] ^ vc_s[4]) ? {FULL, FULL, FULL} : {NONE, NONE, NONE};
            PAT_GRADIENT: pattern_rgb_s = {grad_s, grad_s, grad_s};
            PAT_BOX:      pattern_rgb_s = in_box_s ? {FULL, FULL, FULL} : {NONE, NONE, FULL};
            default:      pattern_rgb_s = {NONE, NONE, NONE};
        endcase

        // Bar tracking counts pixels within a bar instead of dividing x by BAR_W
        if (bar_cnt_cur_s == BAR_LAST) begin
            bar_cnt_d = '0;
            bar_idx_d = (bar_idx_cur_s == 4'd8) ? 4'd8 : bar_idx_cur_s + 4'd1;
        end else begin
            bar_cnt_d = bar_cnt_cur_s + 1'b1;
            bar_idx_d = bar_idx_cur_s;
        end

        // Box moves on the last cycle of a frame, so the new position is live from pixel (0,0)
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        if (frame_end_s) begin
            if (32'(box_x_q) + BOX_DX + BOX_SIZE > H_ACTIVE) begin
                box_x_d = '0;
            end else begin
                box_x_d = box_x_q + X_BITS'(BOX_DX);
            end
            if (32'(box_y_q) + BOX_DY + BOX_SIZE > V_ACTIVE) begin
                box_y_d = '0;
            end else begin
                box_y_d = box_y_q + Y_BITS'(BOX_DY);
            end
        end else begin
            box_x_d = box_x_q;
            box_y_d = box_y_q;
        end

        pat_d         = pat_cur_s;
        rgb_d         = active_s ? pattern_rgb_s : '0;
        blank_d       = ~active_s;
        hsync_d       = hsync_s;
        vsync_d       = vsync_s;
        line_start_d  = line_start_s;
        frame_start_d = frame_start_s;
        frame_count_d = frame_start_s ? frame_count_q + 8'd1 : frame_count_q;
        pix_x_d       = hc_s;
        pix_y_d       = vc_s;
    end

    // Pattern state and output register stage.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            pat_q         <= PAT_SOLID;
            bar_idx_q     <= 4'd0;
            bar_cnt_q     <= '0;
            box_x_q       <= '0;
            box_y_q       <= '0;
            rgb_q         <= '0;
            blank_q       <= 1'b1;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
        end else begin
            pat_q         <= pat_d;
            bar_idx_q     <= bar_idx_d;
            bar_cnt_q     <= bar_cnt_d;
            box_x_q       <= box_x_d;
            box_y_q       <= box_y_d;
            rgb_q         <= rgb_d;
            blank_q       <= blank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
        end
    end

    assign vga_r       = rgb_q[3*C_BITS-1 -: C_BITS];
    assign vga_g       = rgb_q[2*C_BITS-1 -: C_BITS];
    assign vga_b       = rgb_q[C_BITS-1:0];
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_blank   = blank_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_video_gen.sv
// Directed bench for vga_video_gen: a scaled main instance (48x36 active, 64x40 total)
// and a tiny instance with positive hsync.
module tb_vga_video_gen;

    localparam int FRAME = 64 * 40;
    localparam int SFRAME = 24 * 12;
    localparam logic [23:0] WHT = 24'hFFFFFF;
    localparam logic [23:0] BLU = 24'h0000FF;
    localparam logic [23:0] BLK = 24'h000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, s_reset;
    logic [2:0]  pattern_sel;
    logic [23:0] solid_rgb;

    logic [7:0]  m_r, m_g, m_b, m_fc;
    logic        m_hs, m_vs, m_blank, m_ls, m_fs;
    logic [11:0] m_x;
    logic [10:0] m_y;
    logic [7:0]  s_r, s_g, s_b, s_fc;
    logic        s_hs, s_vs, s_blank, s_ls, s_fs;
    logic [11:0] s_x;
    logic [10:0] s_y;
    wire  [23:0] m_rgb = {m_r, m_g, m_b};

    int n_checks = 0;
    int n_fail   = 0;

    localparam int BOX_N = 21;
    int          box_f   [BOX_N] = '{1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3, 9, 9, 9, 10, 10, 10, 11, 11, 11};
    int          box_xs  [BOX_N] = '{0, 31, 32, 31, 31, 2, 1, 2, 33, 34, 3, 4, 15, 16, 47, 0, 0, 32, 0, 1, 2};
    int          box_ys  [BOX_N] = '{0, 0, 0, 31, 32, 0, 1, 1, 1, 1, 2, 2, 3, 3, 3, 3, 4, 4, 0, 0, 0};
    logic [23:0] box_rgb [BOX_N] = '{WHT, WHT, BLU, WHT, BLU, BLU, BLU, WHT, WHT, BLU, BLU, WHT,
                                     BLU, WHT, WHT, BLU, WHT, BLU, BLU, BLU, WHT};

    vga_video_gen #(
        .H_ACTIVE (48), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_ACTIVE (36), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .H_POL (1'b0), .V_POL (1'b0), .C_BITS (8), .X_BITS (12), .Y_BITS (11)
    ) u_dut (
        .clk_pixel (clk), .reset (reset), .pattern_sel (pattern_sel), .solid_rgb (solid_rgb),
        .vga_r (m_r), .vga_g (m_g), .vga_b (m_b), .vga_hsync (m_hs), .vga_vsync (m_vs),
        .vga_blank (m_blank), .pix_x (m_x), .pix_y (m_y), .line_start (m_ls),
        .frame_start (m_fs), .frame_count (m_fc)
    );

    vga_video_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_ACTIVE (8), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .H_POL (1'b1), .V_POL (1'b0), .C_BITS (8), .X_BITS (12), .Y_BITS (11)
    ) u_small (
        .clk_pixel (clk), .reset (s_reset), .pattern_sel (3'd1), .solid_rgb (24'h000000),
        .vga_r (s_r), .vga_g (s_g), .vga_b (s_b), .vga_hsync (s_hs), .vga_vsync (s_vs),
        .vga_blank (s_blank), .pix_x (s_x), .pix_y (s_y), .line_start (s_ls),
        .frame_start (s_fs), .frame_count (s_fc)
    );

    task automatic wait_pix(input int x, input int y);
        int n = 0;
        while (!(m_x == 12'(x) && m_y == 11'(y)) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_frame(input int f);
        int n = 0;
        while (!(m_fs === 1'b1 && m_fc == 8'(f)) && n < 12 * FRAME) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({m_blank, m_hs, m_vs, m_rgb, m_fc, m_fs, m_ls, m_x, m_y} !==
            {1'b1, 1'b1, 1'b1, 24'h0, 8'd0, 1'b0, 1'b0, 12'd0, 11'd0}) begin
            n_fail++;
            $display("FAIL reset_state: blank=%b hs=%b vs=%b rgb=%h fc=%0d fs=%b ls=%b x=%0d y=%0d, want 1 1 1 000000 0 0 0 0 0",
                     m_blank, m_hs, m_vs, m_rgb, m_fc, m_fs, m_ls, m_x, m_y);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({m_x, m_y, m_fs, m_ls, m_fc, m_blank, m_rgb} !==
            {12'd0, 11'd0, 1'b1, 1'b1, 8'd1, 1'b0, WHT}) begin
            n_fail++;
            $display("FAIL first_pixel: x=%0d y=%0d fs=%b ls=%b fc=%0d blank=%b rgb=%h, want 0 0 1 1 1 0 ffffff",
                     m_x, m_y, m_fs, m_ls, m_fc, m_blank, m_rgb);
        end
    endtask

    task automatic test_timing_and_bars();
        int n_act = 0, n_hs = 0, n_vs = 0, n_ls = 0, n_fs = 0, n_dirty = 0;
        logic [23:0] exp_bar;
        logic        has_exp;
        for (int i = 0; i < FRAME; i++) begin
            if (m_blank === 1'b0) n_act++;
            if (m_hs === 1'b0) n_hs++;
            if (m_vs === 1'b0) n_vs++;
            if (m_ls === 1'b1) n_ls++;
            if (m_fs === 1'b1) n_fs++;
            if (m_blank === 1'b1 && m_rgb !== 24'h0) n_dirty++;
            if (m_blank === 1'b0 && m_y == 11'd5) begin
                has_exp = 1'b1;
                exp_bar = BLK;
                case (m_x)
                    12'd0:   exp_bar = WHT;
                    12'd5:   exp_bar = WHT;
                    12'd6:   exp_bar = 24'hFFFF00;
                    12'd12:  exp_bar = 24'h00FFFF;
                    12'd18:  exp_bar = 24'h00FF00;
                    12'd24:  exp_bar = 24'hFF00FF;
                    12'd30:  exp_bar = 24'hFF0000;
                    12'd36:  exp_bar = BLU;
                    12'd47:  exp_bar = BLK;
                    default: has_exp = 1'b0;
                endcase
                if (has_exp) begin
                    n_checks++;
                    if (m_rgb !== exp_bar) begin
                        n_fail++;
                        $display("FAIL bar_x%0d: rgb=%h, want %h", m_x, m_rgb, exp_bar);
                    end
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if ({m_fs, m_fc, m_x, m_y} !== {1'b1, 8'd2, 12'd0, 11'd0}) begin
            n_fail++;
            $display("FAIL frame_period: after %0d cycles fs=%b fc=%0d x=%0d y=%0d, want 1 2 0 0",
                     FRAME, m_fs, m_fc, m_x, m_y);
        end
        n_checks++;
        if ({n_act, n_hs, n_vs, n_ls, n_fs, n_dirty} !== {32'd1728, 32'd240, 32'd128, 32'd40, 32'd1, 32'd0}) begin
            n_fail++;
            $display("FAIL frame_counts: active=%0d hs_low=%0d vs_low=%0d ls=%0d fs=%0d dirty=%0d, want 1728 240 128 40 1 0",
                     n_act, n_hs, n_vs, n_ls, n_fs, n_dirty);
        end
    endtask

    task automatic test_pattern_switch();
        wait_pix(0, 20);
        pattern_sel = 3'd2;
        wait_pix(6, 25);
        n_checks++;
        if ({m_fc, m_y, m_x, m_rgb} !== {8'd2, 11'd25, 12'd6, 24'hFFFF00}) begin
            n_fail++;
            $display("FAIL switch_midframe: fc=%0d (%0d,%0d) rgb=%h, want 2 (6,25) ffff00", m_fc, m_x, m_y, m_rgb);
        end
        wait_pix(0, 0);
        n_checks++;
        if ({m_fc, m_y, m_x, m_rgb} !== {8'd3, 11'd0, 12'd0, BLK}) begin
            n_fail++;
            $display("FAIL switch_0_0: fc=%0d (%0d,%0d) rgb=%h, want 3 (0,0) 000000", m_fc, m_x, m_y, m_rgb);
        end
        wait_pix(16, 0);
        n_checks++;
        if ({m_y, m_x, m_rgb} !== {11'd0, 12'd16, WHT}) begin
            n_fail++;
            $display("FAIL switch_16_0: (%0d,%0d) rgb=%h, want (16,0) ffffff", m_x, m_y, m_rgb);
        end
        wait_pix(0, 16);
        n_checks++;
        if ({m_y, m_x, m_rgb} !== {11'd16, 12'd0, WHT}) begin
            n_fail++;
            $display("FAIL checker_0_16: (%0d,%0d) rgb=%h, want (0,16) ffffff", m_x, m_y, m_rgb);
        end
        wait_pix(16, 16);
        n_checks++;
        if ({m_y, m_x, m_rgb} !== {11'd16, 12'd16, BLK}) begin
            n_fail++;
            $display("FAIL checker_16_16: (%0d,%0d) rgb=%h, want (16,16) 000000", m_x, m_y, m_rgb);
        end
    endtask

    task automatic test_other_patterns();
        pattern_sel = 3'd3;
        wait_pix(0, 0);
        wait_pix(37, 3);
        n_checks++;
        if ({m_y, m_x, m_rgb} !== {11'd3, 12'd37, 24'h252525}) begin
            n_fail++;
            $display("FAIL gradient: (%0d,%0d) rgb=%h, want (37,3) 252525", m_x, m_y, m_rgb);
        end
        pattern_sel = 3'd0;
        solid_rgb   = 24'h123456;
        wait_pix(0, 0);
        wait_pix(5, 5);
        n_checks++;
        if ({m_y, m_x, m_rgb} !== {11'd5, 12'd5, 24'h123456}) begin
            n_fail++;
            $display("FAIL solid: (%0d,%0d) rgb=%h, want (5,5) 123456", m_x, m_y, m_rgb);
        end
        pattern_sel = 3'd5;
        wait_pix(0, 0);
        wait_pix(5, 5);
        n_checks++;
        if ({m_y, m_x, m_blank, m_rgb} !== {11'd5, 12'd5, 1'b0, BLK}) begin
            n_fail++;
            $display("FAIL pattern5_black: (%0d,%0d) blank=%b rgb=%h, want (5,5) 0 000000", m_x, m_y, m_blank, m_rgb);
        end
    endtask

    task automatic test_mid_reset();
        wait_pix(30, 20);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({m_blank, m_hs, m_vs, m_fc, m_fs, m_rgb} !== {1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 24'h0}) begin
                n_fail++;
                $display("FAIL mid_reset_c%0d: blank=%b hs=%b vs=%b fc=%0d fs=%b rgb=%h, want 1 1 1 0 0 000000",
                         k, m_blank, m_hs, m_vs, m_fc, m_fs, m_rgb);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({m_x, m_y, m_fs, m_fc} !== {12'd0, 11'd0, 1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL mid_reset_release: x=%0d y=%0d fs=%b fc=%0d, want 0 0 1 1", m_x, m_y, m_fs, m_fc);
        end
    endtask

    task automatic test_box();
        pattern_sel = 3'd4;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < BOX_N; i++) begin
            if (m_fc != 8'(box_f[i])) wait_frame(box_f[i]);
            wait_pix(box_xs[i], box_ys[i]);
            n_checks++;
            if ({m_fc, m_y, m_x, m_rgb} !== {8'(box_f[i]), 11'(box_ys[i]), 12'(box_xs[i]), box_rgb[i]}) begin
                n_fail++;
                $display("FAIL box_%0d: fc=%0d (%0d,%0d) rgb=%h, want fc=%0d (%0d,%0d) %h",
                         i, m_fc, m_x, m_y, m_rgb, box_f[i], box_xs[i], box_ys[i], box_rgb[i]);
            end
        end
    endtask

    task automatic test_small_params();
        int bad_hs = 0, n_hs = 0, n_vs = 0, n_fs = 0, first_fs = -1, second_fs = -1;
        s_reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2 * SFRAME; i++) begin
            if (s_hs !== ((s_x >= 12'd18) && (s_x <= 12'd21))) bad_hs++;
            if (s_hs === 1'b1) n_hs++;
            if (s_vs === 1'b0) n_vs++;
            if (s_fs === 1'b1) begin
                n_fs++;
                if (first_fs < 0) first_fs = i;
                else if (second_fs < 0) second_fs = i;
            end
            @(negedge clk);
        end
        n_checks++;
        if (second_fs - first_fs != SFRAME || first_fs != 0) begin
            n_fail++;
            $display("FAIL small_period: frame_start at %0d and %0d, want 0 and %0d", first_fs, second_fs, SFRAME);
        end
        n_checks++;
        if ({bad_hs, n_hs, n_vs, n_fs} !== {32'd0, 32'd96, 32'd96, 32'd2}) begin
            n_fail++;
            $display("FAIL small_sync: bad_hs=%0d hs_high=%0d vs_low=%0d fs=%0d, want 0 96 96 2",
                     bad_hs, n_hs, n_vs, n_fs);
        end
        n_checks++;
        if ({s_fs, s_fc} !== {1'b1, 8'd3}) begin
            n_fail++;
            $display("FAIL small_wrap: fs=%b fc=%0d, want 1 3", s_fs, s_fc);
        end
    endtask

    initial begin
        reset       = 1'b1;
        s_reset     = 1'b1;
        pattern_sel = 3'd1;
        solid_rgb   = 24'h000000;
        @(negedge clk);
        test_reset();
        test_timing_and_bars();
        test_pattern_switch();
        test_other_patterns();
        test_mid_reset();
        test_box();
        test_small_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
